clock_lock_monitor: RTL and testbench

CLOCK_LOCK_MONITOR -- requirements
Module: clock_lock_monitor

---
 rtl/clock_lock_monitor.sv | 132 +++++++++++++
 tb/tb_clock_lock_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clock_lock_monitor.sv
// Clock lock monitor: counts synchronized MON_CLK edges per WINDOW and tracks lock.
// Optional macro CLOCK_LOCK_MONITOR_LOSS_COUNT_EN enables the saturating loss counter.
module clock_lock_monitor #(
  parameter int unsigned WINDOW     = 1000,
  parameter int unsigned EXP_MIN    = 95,
  parameter int unsigned EXP_MAX    = 105,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        mon_clk_i,
  output logic        locked_o,
  output logic        reset_out_n_o,
  output logic [15:0] freq_count_o,
  output logic        freq_valid_o,
  output logic        loss_pulse_o,
  output logic [7:0]  loss_count_o
);

  localparam logic [1:0]  ST_ACQUIRE = 2'd0;
  localparam logic [1:0]  ST_LOCKED  = 2'd1;
  localparam logic [1:0]  ST_LOST    = 2'd2;
  localparam logic [15:0] WIN_LAST   = 16'(WINDOW - 1);
  localparam logic [16:0] MIN_L      = 17'(EXP_MIN);
  localparam logic [16:0] MAX_L      = 17'(EXP_MAX);
  localparam logic [7:0]  LOCK_L     = 8'(LOCK_COUNT);

  logic [2:0]  sync_q;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [15:0] final_count;
  logic [15:0] freq_count_q;
  logic        freq_valid_q;
  logic [1:0]  state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, rst_out_q, loss_pulse_q;
  logic        edge_det, win_end, window_good;

  // sync_q[1] is the second synchronizer stage, sync_q[2] its delayed copy
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign win_end  = (win_cnt_q == WIN_LAST);

  // Count including this cycle's edge, so a window-end edge belongs to the ending window
  assign final_count = (edge_cnt_q == 16'hFFFF) ? edge_cnt_q
                                                : edge_cnt_q + {15'd0, edge_det};
  assign window_good = ({1'b0, final_count} >= MIN_L) && ({1'b0, final_count} <= MAX_L);

  always_comb begin
    win_cnt_d  = win_end ? 16'd0 : win_cnt_q + 16'd1;
    edge_cnt_d = win_end ? {15'd0, edge_det} : final_count;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (win_end) begin
          if (!window_good) begin
            good_cnt_d = 8'd0;
          end else if (good_cnt_q + 8'd1 == LOCK_L) begin
            good_cnt_d = 8'd0;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (win_end && !window_good) begin
          state_d = ST_LOST;
        end
      end
      default: begin
        state_d    = ST_ACQUIRE;
        good_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q       <= 3'd0;
      win_cnt_q    <= 16'd0;
      edge_cnt_q   <= 16'd0;
      freq_count_q <= 16'd0;
      freq_valid_q <= 1'b0;
      state_q      <= ST_ACQUIRE;
      good_cnt_q   <= 8'd0;
      locked_q     <= 1'b0;
      rst_out_q    <= 1'b0;
      loss_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], mon_clk_i};
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      if (win_end) begin
        freq_count_q <= final_count;
      end
      freq_valid_q <= win_end;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= (state_d == ST_LOCKED);
      // Released one cycle after lock, dropped together with lock
      rst_out_q    <= locked_q && (state_d == ST_LOCKED);
      loss_pulse_q <= (state_d == ST_LOST);
    end
  end

`ifdef CLOCK_LOCK_MONITOR_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      loss_cnt_q <= 8'd0;
    end else if (loss_pulse_q && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign loss_count_o = loss_cnt_q;
`else
  assign loss_count_o = 8'd0;
`endif

  assign locked_o      = locked_q;
  assign reset_out_n_o = rst_out_q;
  assign freq_count_o  = freq_count_q;
  assign freq_valid_o  = freq_valid_q;
  assign loss_pulse_o  = loss_pulse_q;

endmodule

// File: tb/tb_clock_lock_monitor.sv
// Window-by-window directed bench for clock_lock_monitor (default parameters).
// MON_CLK gets an exact edge count per window; each record lists the expected outcome.
module tb_clock_lock_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mon_clk = 1'b0;
  logic        locked, reset_out_n, freq_valid, loss_pulse;
  logic [15:0] freq_count;
  logic [7:0]  loss_count;

  clock_lock_monitor dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .mon_clk_i    (mon_clk),
    .locked_o     (locked),
    .reset_out_n_o(reset_out_n),
    .freq_count_o (freq_count),
    .freq_valid_o (freq_valid),
    .loss_pulse_o (loss_pulse),
    .loss_count_o (loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;        // pulses in the window
    int stuck;    // MON_CLK held high all window
    int tail;     // extra rising edge late in the window, then held high
    int pre_rst;  // reset pulse in the middle of the preceding window
    int cnt;      // expected FREQ_COUNT
    int lock;     // expected LOCKED at the FREQ_VALID cycle
    int rst_now;  // expected RESET_OUT_N at the FREQ_VALID cycle
    int loss;     // expected LOSS_PULSE at the FREQ_VALID cycle
    int losses;   // lock losses since reset, one cycle later
  } vec_t;

  int n_next = 0, stuck_next = 0, tail_next = 0;
  int n_win = 0, stuck_win = 0, tail_win = 0;
  int kcnt = 0;
  int checks = 0;
  int failures = 0;

  // Waveform source; pulses sit well inside the window so the 3-cycle sync delay never crosses it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        kcnt    = 0;
        mon_clk = 1'b0;
      end else begin
        int k;
        k = kcnt % 1000;
        if (k == 5) begin
          n_win     = n_next;
          stuck_win = stuck_next;
          tail_win  = tail_next;
        end
        if (k >= 5) begin
          if (stuck_win != 0)                   mon_clk = 1'b1;
          else if (tail_win != 0 && k >= 800)   mon_clk = 1'b1;
          else mon_clk = (k >= 10 && k < 10 + 6 * n_win && ((k - 10) % 6) < 3);
        end
        kcnt++;
      end
    end
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic int exp_losses(input int v);
`ifdef CLOCK_LOCK_MONITOR_LOSS_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check_reset_state(input int idx);
    check("rst_locked",     idx, int'(locked),      0);
    check("rst_reset_out",  idx, int'(reset_out_n), 0);
    check("rst_freq_count", idx, int'(freq_count),  0);
    check("rst_freq_valid", idx, int'(freq_valid),  0);
    check("rst_loss_pulse", idx, int'(loss_pulse),  0);
    check("rst_loss_count", idx, int'(loss_count),  0);
  endtask

  vec_t vec[33];

  initial begin
    vec[0]  = '{100,0,0,0, 100,0,0,0,0};
    vec[1]  = '{ 95,0,0,0,  95,0,0,0,0};
    vec[2]  = '{ 94,0,0,0,  94,0,0,0,0};
    vec[3]  = '{105,0,0,0, 105,0,0,0,0};
    vec[4]  = '{106,0,0,0, 106,0,0,0,0};
    vec[5]  = '{100,0,0,0, 100,0,0,0,0};
    vec[6]  = '{100,0,0,0, 100,0,0,0,0};
    vec[7]  = '{100,0,0,0, 100,0,0,0,0};
    vec[8]  = '{ 95,0,0,0,  95,1,0,0,0};
    vec[9]  = '{105,0,0,0, 105,1,1,0,0};
    vec[10] = '{125,0,0,0, 125,0,0,1,1};
    vec[11] = '{100,0,0,0, 100,0,0,0,1};
    vec[12] = '{100,0,0,0, 100,0,0,0,1};
    vec[13] = '{100,0,0,0, 100,0,0,0,1};
    vec[14] = '{100,0,0,0, 100,1,0,0,1};
    vec[15] = '{100,0,1,0, 101,1,1,0,1};
    vec[16] = '{  0,1,0,0,   0,0,0,1,2};
    vec[17] = '{  0,1,0,0,   0,0,0,0,2};
    vec[18] = '{100,0,0,0, 100,0,0,0,2};
    vec[19] = '{100,0,0,0, 100,0,0,0,2};
    vec[20] = '{100,0,0,0, 100,0,0,0,2};
    vec[21] = '{100,0,0,0, 100,1,0,0,2};
    vec[22] = '{ 94,0,0,0,  94,0,0,1,3};
    vec[23] = '{100,0,0,0, 100,0,0,0,3};
    vec[24] = '{100,0,0,0, 100,0,0,0,3};
    vec[25] = '{100,0,0,0, 100,0,0,0,3};
    vec[26] = '{100,0,0,0, 100,1,0,0,3};
    vec[27] = '{100,0,0,0, 100,1,1,0,3};
    vec[28] = '{100,0,0,1, 100,0,0,0,0};
    vec[29] = '{100,0,0,0, 100,0,0,0,0};
    vec[30] = '{100,0,0,0, 100,0,0,0,0};
    vec[31] = '{100,0,0,0, 100,1,0,0,0};
    vec[32] = '{100,0,0,0, 100,1,1,0,0};

    repeat (3) @(negedge clk);
    check_reset_state(-1);
    rst_n = 1'b1;

    for (int i = 0; i < 33; i++) begin
      int waited;
      if (vec[i].pre_rst != 0) begin
        // Abort the running window while locked; outputs must clear without a clock edge
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state(i);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      n_next     = vec[i].n;
      stuck_next = vec[i].stuck;
      tail_next  = vec[i].tail;

      waited = 0;
      while (!freq_valid && waited < 1200) begin
        @(negedge clk);
        waited++;
      end
      check("window_timeout", i, int'(freq_valid), 1);
      check("freq_count",  i, int'(freq_count),  vec[i].cnt);
      check("locked",      i, int'(locked),      vec[i].lock);
      check("reset_out_n", i, int'(reset_out_n), vec[i].rst_now);
      check("loss_pulse",  i, int'(loss_pulse),  vec[i].loss);
      $display("window %0d: count=%0d locked=%0d reset_out_n=%0d loss_pulse=%0d loss_count=%0d",
               i, freq_count, locked, reset_out_n, loss_pulse, loss_count);

      @(negedge clk);
      check("freq_valid_1cyc",   i, int'(freq_valid),  0);
      check("loss_pulse_1cyc",   i, int'(loss_pulse),  0);
      check("locked_next",       i, int'(locked),      vec[i].lock);
      check("reset_out_n_next",  i, int'(reset_out_n), vec[i].lock);
      check("loss_count",        i, int'(loss_count),  exp_losses(vec[i].losses));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
